// File: rtl/grid_load_sequencer.sv
// grid_load_sequencer: shifts one row word MSB-first into system_memory_v2,
// then drives run_mode for gen_count unstalled cycles and pulses done.
module grid_load_sequencer #(
    parameter int DATA_SIZE = 5,
    parameter int GEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] word_in,
    input  logic [GEN_WIDTH-1:0] gen_count,
    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic                 hold,
    output logic                 serial_out,
    output logic                 load_mode,
    output logic                 run_mode,
    output logic                 busy,
    output logic                 done
);
    localparam int BW = $clog2(DATA_SIZE);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [GEN_WIDTH-1:0] gen_q, gen_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            gen_q   <= gen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        gen_d   = gen_q;
        case (state_q)
            IDLE: if (word_valid) begin
                shift_d = word_in;
                gen_d   = gen_count;
                bit_d   = '0;
                state_d = LOAD;
            end
            LOAD: if (!hold) begin
                shift_d = {shift_q[DATA_SIZE-2:0], 1'b0};
                bit_d   = bit_q + 1'b1;
                if (bit_q == BW'(DATA_SIZE - 1))
                    state_d = (gen_q != '0) ? RUN : DONE;
            end
            RUN: if (!hold) begin
                gen_d = gen_q - 1'b1;
                if (gen_q == GEN_WIDTH'(1))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // hold is the only input allowed to reach the mode outputs combinationally
    assign word_ready = reset && (state_q == IDLE);
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign load_mode  = (state_q == LOAD) && !hold;
    assign run_mode   = (state_q == RUN) && !hold;
    assign serial_out = (state_q == LOAD) && shift_q[DATA_SIZE-1];
endmodule
